// File: rtl/divu_hilo_if.sv
// Start/operand/result bundle between the EX-stage ALU control and the HI/LO divider.
interface divu_hilo_if #(
   parameter int unsigned WIDTH = 32
);
   logic             divReset;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             busy;
   logic             done;
   logic             div_zero;

   modport master (
      output divReset, dividend, divisor,
      input  hi, lo, busy, done, div_zero
   );

   modport slave (
      input  divReset, dividend, divisor,
      output hi, lo, busy, done, div_zero
   );
endinterface

// File: rtl/divu_hilo.sv
// Multi-cycle restoring unsigned divider; quotient lands in LO, remainder in HI.
module divu_hilo #(
   parameter int unsigned WIDTH = 32
) (
   input logic        clk,
   input logic        reset,
   divu_hilo_if.slave bus
);
   localparam int unsigned CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] dvsr, q, rem;
   logic [CW-1:0]    cnt;

   logic             start_c, zero_c, last_c, ge_c;
   logic [WIDTH:0]   rem_sh_c;
   logic [WIDTH-1:0] rem_nxt_c, q_nxt_c;

   // One restoring step; the extra top bit keeps the shifted remainder from overflowing.
   always_comb begin
      rem_sh_c  = {rem, q[WIDTH-1]};
      ge_c      = (rem_sh_c >= {1'b0, dvsr});
      rem_nxt_c = ge_c ? WIDTH'(rem_sh_c - {1'b0, dvsr}) : rem_sh_c[WIDTH-1:0];
      q_nxt_c   = {q[WIDTH-2:0], ge_c};
   end

   assign start_c = bus.divReset && (state != RUN);
   assign zero_c  = (bus.divisor == '0);
   assign last_c  = (cnt == CW'(WIDTH - 1));

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE: begin
            if (start_c) state_nxt = zero_c ? DONE : RUN;
            else         state_nxt = IDLE;
         end
         RUN: begin
            if (last_c) state_nxt = DONE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         dvsr         <= '0;
         q            <= '0;
         rem          <= '0;
         cnt          <= '0;
         bus.hi       <= '0;
         bus.lo       <= '0;
         bus.busy     <= 1'b0;
         bus.done     <= 1'b0;
         bus.div_zero <= 1'b0;
      end else begin
         state    <= state_nxt;
         bus.busy <= (state_nxt == RUN);
         bus.done <= (state_nxt == DONE);
         if (start_c) begin
            if (zero_c) begin
               // Divide-by-zero completes at the accept edge without iterating.
               bus.hi       <= bus.dividend;
               bus.lo       <= '1;
               bus.div_zero <= 1'b1;
            end else begin
               dvsr         <= bus.divisor;
               q            <= bus.dividend;
               rem          <= '0;
               cnt          <= '0;
               bus.div_zero <= 1'b0;
            end
         end else if (state == RUN) begin
            q   <= q_nxt_c;
            rem <= rem_nxt_c;
            cnt <= cnt + CW'(1);
            if (last_c) begin
               bus.hi <= rem_nxt_c;
               bus.lo <= q_nxt_c;
            end
         end
      end
   end
endmodule

// File: tb/tb_divu_hilo.sv
// Directed and random checks of divu_hilo against an arithmetic reference model.
module tb_divu_hilo;
   localparam int unsigned W = 32;

   logic clk;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   logic [W-1:0] exp_hi, exp_lo;
   logic         exp_dz;

   divu_hilo_if #(.WIDTH(W)) bus ();

   divu_hilo #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present operands with divReset for one edge, then scramble the operand lines.
   task automatic start(input logic [W-1:0] a, input logic [W-1:0] b);
      bus.dividend = a;
      bus.divisor  = b;
      bus.divReset = 1'b1;
      step();
      bus.divReset = 1'b0;
      bus.dividend = $urandom;
      bus.divisor  = $urandom;
   endtask

   // Count busy cycles until done; hi/lo must hold the previous result meanwhile.
   // A divReset with 9/3 is injected after ign_at busy cycles when ign_at >= 0.
   task automatic wait_done(input int ign_at, output int bcnt);
      bit seen = 0;
      bcnt = 0;
      for (int i = 0; i < 100; i++) begin
         bus.divReset = 1'b0;
         if (bus.done) begin
            seen = 1;
            break;
         end
         if (bus.busy) bcnt++;
         chk("hold_hi", 64'(bus.hi), 64'(exp_hi));
         chk("hold_lo", 64'(bus.lo), 64'(exp_lo));
         if (bcnt == ign_at && ign_at >= 0 && bus.busy) begin
            bus.dividend = 9;
            bus.divisor  = 3;
            bus.divReset = 1'b1;
         end
         step();
      end
      bus.divReset = 1'b0;
      chk("done_seen", 64'(seen), 64'd1);
   endtask

   // Reference result from plain arithmetic.
   task automatic model(input logic [W-1:0] a, input logic [W-1:0] b);
      if (b == '0) begin
         exp_hi = a;
         exp_lo = '1;
         exp_dz = 1'b1;
      end else begin
         exp_hi = a % b;
         exp_lo = a / b;
         exp_dz = 1'b0;
      end
   endtask

   task automatic check_result(input string tag, input logic [W-1:0] b, input int bcnt);
      chk({tag, "_hi"}, 64'(bus.hi), 64'(exp_hi));
      chk({tag, "_lo"}, 64'(bus.lo), 64'(exp_lo));
      chk({tag, "_dz"}, 64'(bus.div_zero), 64'(exp_dz));
      chk({tag, "_busycyc"}, 64'(bcnt), (b == '0) ? 64'd0 : 64'(W));
   endtask

   task automatic do_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
      int bcnt;
      start(a, b);
      wait_done(-1, bcnt);
      model(a, b);
      check_result(tag, b, bcnt);
      step();
      chk({tag, "_done_once"}, 64'(bus.done), 64'd0);
      chk({tag, "_idle"}, 64'(bus.busy), 64'd0);
   endtask

   initial begin
      int bcnt;
      int extra;
      logic [W-1:0] a, b;

      exp_hi = '0;
      exp_lo = '0;
      exp_dz = 1'b0;

      // Reset held together with a start request: reset must win.
      reset        = 1'b1;
      bus.divReset = 1'b1;
      bus.dividend = 100;
      bus.divisor  = 7;
      step();
      step();
      reset        = 1'b0;
      bus.divReset = 1'b0;
      chk("rst_hi", 64'(bus.hi), 64'd0);
      chk("rst_lo", 64'(bus.lo), 64'd0);
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_done", 64'(bus.done), 64'd0);
      chk("rst_dz", 64'(bus.div_zero), 64'd0);
      step();
      chk("rst_override_busy", 64'(bus.busy), 64'd0);

      do_div("basic", 100, 7);
      do_div("max_by_1", 32'hFFFF_FFFF, 1);
      do_div("small_by_max", 5, 32'hFFFF_FFFF);

      // Divide by zero, then a normal start must clear div_zero.
      do_div("divzero", 32'h1234_5678, 0);
      step();
      chk("dz_sticky", 64'(bus.div_zero), 64'd1);
      do_div("after_dz", 81, 9);

      // divReset while busy is ignored.
      start(100, 7);
      wait_done(10, bcnt);
      model(100, 7);
      check_result("busy_ign", 7, bcnt);
      extra = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (bus.done || bus.busy) extra++;
      end
      chk("busy_ign_no_second", 64'(extra), 64'd0);

      // Reset in the middle of a run aborts without a result.
      start(100, 7);
      repeat (14) step();
      chk("mid_busy", 64'(bus.busy), 64'd1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      exp_hi = '0;
      exp_lo = '0;
      exp_dz = 1'b0;
      chk("abort_busy", 64'(bus.busy), 64'd0);
      chk("abort_done", 64'(bus.done), 64'd0);
      chk("abort_hi", 64'(bus.hi), 64'd0);
      chk("abort_lo", 64'(bus.lo), 64'd0);
      do_div("post_abort", 50, 8);

      // Back-to-back: second start issued in the DONE cycle.
      start(100, 7);
      wait_done(-1, bcnt);
      model(100, 7);
      check_result("b2b_first", 7, bcnt);
      start(20, 6);
      chk("b2b_busy_rise", 64'(bus.busy), 64'd1);
      chk("b2b_done_low", 64'(bus.done), 64'd0);
      wait_done(-1, bcnt);
      model(20, 6);
      check_result("b2b_second", 6, bcnt);
      step();

      // Random operands, with occasional zero and small divisors.
      for (int n = 0; n < 24; n++) begin
         a = $urandom;
         case ($urandom_range(0, 3))
            0:       b = '0;
            1:       b = W'($urandom_range(1, 255));
            2:       b = a >> $urandom_range(0, 31);
            default: b = $urandom;
         endcase
         do_div("rand", a, b);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
